// File: rtl/facto_core_if.sv
// facto_core_if: register bus between a host and facto_core.
interface facto_core_if;
    logic        s_sel;
    logic        s_wr;
    logic [15:0] s_addr;
    logic [63:0] s_din;
    logic [63:0] s_dout;
    modport master (output s_sel, s_wr, s_addr, s_din, input s_dout);
    modport slave (input s_sel, s_wr, s_addr, s_din, output s_dout);
endinterface

// File: rtl/facto_core.sv
// facto_core: register-mapped n! engine built from 128-bit shift-and-add multiplies.
// Define FACTO_OVERFLOW_FLAG_EN to add a sticky overflow flag in OPDONE bit2.
module facto_core (
    input  logic        clk,
    input  logic        reset_n,
    facto_core_if.slave bus,
    output logic        interrupt
);
    typedef enum logic [2:0] {IDLE, INIT, MUL, NEXT, DONE} state_t;
    state_t state, state_nx;
    logic opstart, opclear, intren, busy, done, wr, clr, unused_addr;
    logic [7:0] a;
    logic [63:0] operand, cnt, cnt_nx, mplier, mplier_nx, rd;
    logic [127:0] result, acc, mcand, result_nx, acc_nx, mcand_nx;
`ifdef FACTO_OVERFLOW_FLAG_EN
    logic ovf, ovf_nx;
    logic [128:0] sum;
    assign sum = {1'b0, acc} + {1'b0, mcand};
`else
    logic [127:0] sum;
    assign sum = acc + mcand;
`endif
    assign a = bus.s_addr[7:0];
    assign unused_addr = ^bus.s_addr[15:8];
    assign wr = bus.s_sel && bus.s_wr;
    assign clr = wr && a == 8'h08 && bus.s_din[0];
    assign busy = state == INIT || state == MUL || state == NEXT;
    assign done = state == DONE;
    assign interrupt = intren && done;
    always_comb begin
        state_nx = state;
        result_nx = result;
        acc_nx = acc;
        mcand_nx = mcand;
        mplier_nx = mplier;
        cnt_nx = cnt;
`ifdef FACTO_OVERFLOW_FLAG_EN
        ovf_nx = ovf;
`endif
        case (state)
            IDLE: state_nx = (wr && a == 8'h00 && bus.s_din[0]) ? INIT : IDLE;
            INIT: begin
                result_nx = 128'd1;
                cnt_nx = operand;
                acc_nx = '0;
                mcand_nx = 128'd1;
                mplier_nx = operand;
                state_nx = (operand <= 64'd1) ? DONE : MUL;
            end
            MUL: begin
                acc_nx = mplier[0] ? sum[127:0] : acc;
                mcand_nx = mcand << 1;
                mplier_nx = mplier >> 1;
                state_nx = (mplier_nx == 64'd0) ? NEXT : MUL;
`ifdef FACTO_OVERFLOW_FLAG_EN
                // a carry out, or a set bit shifted out while multiplier bits remain, means the true product needs >128 bits
                if ((mplier[0] && sum[128]) || (mcand[127] && mplier[63:1] != 63'd0))
                    ovf_nx = 1'b1;
`endif
            end
            NEXT: begin
                result_nx = acc;
                cnt_nx = cnt - 64'd1;
                acc_nx = '0;
                mcand_nx = acc;
                mplier_nx = cnt_nx;
                state_nx = (cnt_nx <= 64'd1) ? DONE : MUL;
            end
            DONE: state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (clr) begin
            state_nx = IDLE;
            result_nx = '0;
`ifdef FACTO_OVERFLOW_FLAG_EN
            ovf_nx = 1'b0;
`endif
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            opstart <= 1'b0;
            opclear <= 1'b0;
            intren <= 1'b0;
            operand <= '0;
            result <= '0;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            cnt <= '0;
`ifdef FACTO_OVERFLOW_FLAG_EN
            ovf <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            result <= result_nx;
            acc <= acc_nx;
            mcand <= mcand_nx;
            mplier <= mplier_nx;
            cnt <= cnt_nx;
`ifdef FACTO_OVERFLOW_FLAG_EN
            ovf <= ovf_nx;
`endif
            if (wr && a == 8'h08) opclear <= bus.s_din[0];
            if (wr && a == 8'h18) intren <= bus.s_din[0];
            if (wr && a == 8'h20 && !busy) operand <= bus.s_din;
            if (clr) opstart <= 1'b0;
            else if (wr && a == 8'h00 && state == IDLE) opstart <= bus.s_din[0];
        end
    end
    always_comb begin
        case (a)
            8'h00: rd = {63'd0, opstart};
            8'h08: rd = {63'd0, opclear};
`ifdef FACTO_OVERFLOW_FLAG_EN
            8'h10: rd = {61'd0, ovf, done, busy};
`else
            8'h10: rd = {62'd0, done, busy};
`endif
            8'h18: rd = {63'd0, intren};
            8'h20: rd = operand;
            8'h28: rd = result[127:64];
            8'h30: rd = result[63:0];
            default: rd = '0;
        endcase
    end
    assign bus.s_dout = (bus.s_sel && !bus.s_wr) ? rd : '0;
endmodule

// File: tb/tb_facto_core.sv
// tb_facto_core: directed register-level checks of facto_core against hand-computed factorials.
module tb_facto_core;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic interrupt;
    int n_chk = 0;
    int n_fail = 0;
    facto_core_if bus ();
    facto_core dut (.clk(clk), .reset_n(reset_n), .bus(bus), .interrupt(interrupt));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic wr_reg(input logic [15:0] addr, input logic [63:0] data);
        @(negedge clk);
        bus.s_sel = 1'b1;
        bus.s_wr = 1'b1;
        bus.s_addr = addr;
        bus.s_din = data;
        @(posedge clk);
        #1;
        bus.s_sel = 1'b0;
        bus.s_wr = 1'b0;
    endtask
    task automatic rd_reg(input logic [15:0] addr, output logic [63:0] data);
        bus.s_sel = 1'b1;
        bus.s_wr = 1'b0;
        bus.s_addr = addr;
        #1;
        data = bus.s_dout;
        bus.s_sel = 1'b0;
    endtask
    task automatic wait_done(output int cyc);
        logic [63:0] v;
        cyc = 0;
        rd_reg(16'h10, v);
        while (!v[1] && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            rd_reg(16'h10, v);
        end
        check("done_reached", {63'd0, v[1]}, 64'd1);
    endtask
    task automatic run(input logic [63:0] n, output int cyc);
        wr_reg(16'h08, 64'd1);
        wr_reg(16'h20, n);
        wr_reg(16'h00, 64'd1);
        wait_done(cyc);
    endtask
    initial begin
        logic [63:0] v;
        int cyc;
        bus.s_sel = 1'b0;
        bus.s_wr = 1'b0;
        bus.s_addr = '0;
        bus.s_din = '0;
        #12;
        rd_reg(16'h10, v); check("rst_opdone", v, 64'd0);
        check("rst_irq", {63'd0, interrupt}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd_reg(16'h30, v); check("rst_result_l", v, 64'd0);
        rd_reg(16'h20, v); check("rst_operand", v, 64'd0);
        wr_reg(16'h18, 64'd1);
        wr_reg(16'h20, 64'd5);
        wr_reg(16'h00, 64'd1);
        wait_done(cyc);
        check("lat_5", cyc, 64'd15);
        rd_reg(16'h30, v); check("f5_l", v, 64'h78);
        rd_reg(16'h28, v); check("f5_h", v, 64'd0);
        rd_reg(16'h10, v); check("f5_opdone", v, 64'h2);
        check("f5_irq", {63'd0, interrupt}, 64'd1);
        wr_reg(16'h00, 64'd1);
        rd_reg(16'h10, v); check("start_in_done", v, 64'h2);
        wr_reg(16'h08, 64'd1);
        rd_reg(16'h10, v); check("clr_opdone", v, 64'd0);
        rd_reg(16'h30, v); check("clr_result", v, 64'd0);
        rd_reg(16'h00, v); check("clr_opstart", v, 64'd0);
        rd_reg(16'h20, v); check("clr_keep_operand", v, 64'd5);
        rd_reg(16'h18, v); check("clr_keep_intren", v, 64'd1);
        check("clr_irq", {63'd0, interrupt}, 64'd0);
        run(64'd10, cyc);
        rd_reg(16'h30, v); check("f10_l", v, 64'h375F00);
        rd_reg(16'h28, v); check("f10_h", v, 64'd0);
        check("f10_irq", {63'd0, interrupt}, 64'd1);
        run(64'd0, cyc);
        check("lat_0", cyc, 64'd1);
        rd_reg(16'h30, v); check("f0_l", v, 64'd1);
        run(64'd1, cyc);
        check("lat_1", cyc, 64'd1);
        rd_reg(16'h30, v); check("f1_l", v, 64'd1);
        run(64'd21, cyc);
        rd_reg(16'h28, v); check("f21_h", v, 64'h2);
        rd_reg(16'h30, v); check("f21_l", v, 64'hC5077D36B8C40000);
        rd_reg(16'h10, v); check("f21_opdone", v, 64'h2);
        run(64'd35, cyc);
        rd_reg(16'h10, v);
`ifdef FACTO_OVERFLOW_FLAG_EN
        check("f35_ovf", v, 64'h6);
`else
        check("f35_noovf", v, 64'h2);
`endif
        wr_reg(16'h08, 64'd1);
        rd_reg(16'h10, v); check("ovf_cleared", v, 64'd0);
        wr_reg(16'h20, 64'd5);
        wr_reg(16'h00, 64'd1);
        wr_reg(16'h20, 64'd9);
        wr_reg(16'h70FF, 64'hFFFF);
        wr_reg(16'h30, 64'h1234);
        wr_reg(16'h00, 64'd1);
        rd_reg(16'h10, v); check("busy_mid", v, 64'h1);
        rd_reg(16'h20, v); check("busy_operand", v, 64'd5);
        rd_reg(16'h70FF, v); check("unmapped_rd", v, 64'd0);
        wait_done(cyc);
        rd_reg(16'h30, v); check("stray_f5", v, 64'h78);
        wr_reg(16'h08, 64'd1);
        wr_reg(16'h00, 64'd1);
        repeat (4) @(posedge clk);
        #1;
        wr_reg(16'h08, 64'd1);
        rd_reg(16'h10, v); check("midclr_opdone", v, 64'd0);
        rd_reg(16'h30, v); check("midclr_result", v, 64'd0);
        repeat (20) @(posedge clk);
        #1;
        rd_reg(16'h10, v); check("midclr_idle", v, 64'd0);
        wr_reg(16'h18, 64'd0);
        run(64'd3, cyc);
        rd_reg(16'h30, v); check("f3_l", v, 64'd6);
        rd_reg(16'h10, v); check("noirq_opdone", v, 64'h2);
        check("noirq_irq", {63'd0, interrupt}, 64'd0);
        wr_reg(16'h18, 64'd1);
        run(64'd4, cyc);
        wr_reg(16'h08, 64'd1);
        wr_reg(16'h00, 64'd1);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        rd_reg(16'h10, v); check("arst_opdone", v, 64'd0);
        rd_reg(16'h20, v); check("arst_operand", v, 64'd0);
        rd_reg(16'h18, v); check("arst_intren", v, 64'd0);
        check("arst_irq", {63'd0, interrupt}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rd_reg(16'h10, v); check("arst_stays_idle", v, 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
